quantize_block: RTL and testbench

//  Encoder-side counterpart of the block dequantizer/IDCT path. Takes one BLOCK_SIZE x BLOCK_SIZE

---
 rtl/quantize_block.sv | 219 +++++++++++++++++++++
 tb/tb_quantize_block.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quantize_block.sv
// quantize_block
//   Quantizes one BLOCK_SIZE x BLOCK_SIZE block of signed forward-DCT coefficients into signed
//   9-bit values. Each coefficient is divided by its table step using one shared restoring divider
//   that produces one quotient bit per cycle. The quotient is rounded half away from zero and
//   saturated to [-256, 255].
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   start_block_i       start request, sampled only while idle
//   dct_coeffs_i        signed DCT coefficients, [row][col]
//   quant_table_i       unsigned quantizer step per coefficient (0 acts as 1)
//   quantized_coeffs_o  registered quantized result, [row][col]
//   busy_o              high from the start-sampling edge until the return to idle
//   block_done_o        one-cycle pulse; every output element holds the new block
module quantize_block #(
    parameter int unsigned BLOCK_SIZE      = 8,
    parameter int unsigned LOG2_BLOCK_SIZE = 3,
    parameter int unsigned COEF_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_block_i,
    input  logic signed [COEF_WIDTH-1:0] dct_coeffs_i       [BLOCK_SIZE][BLOCK_SIZE],
    input  logic        [7:0]            quant_table_i      [BLOCK_SIZE][BLOCK_SIZE],
    output logic signed [8:0]            quantized_coeffs_o [BLOCK_SIZE][BLOCK_SIZE],
    output logic                         busy_o,
    output logic                         block_done_o
);

    localparam int unsigned NumCoef = BLOCK_SIZE * BLOCK_SIZE;
    localparam int unsigned IdxW    = 2 * LOG2_BLOCK_SIZE;
    // The dividend is one bit wider than a coefficient so |most-negative| fits exactly.
    localparam int unsigned NW      = COEF_WIDTH + 1;
    localparam int unsigned CntW    = $clog2(NW);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDivide,
        StStore,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Dividend shifts out MSB first while quotient bits shift in at the LSB; after NW steps the
    // register holds the full quotient.
    logic [NW-1:0]   dvd_q, dvd_d;
    logic [7:0]      rem_q, rem_d;
    logic [7:0]      div_q, div_d;
    logic            neg_q, neg_d;
    logic            snap;
    logic            store_en;

    logic signed [COEF_WIDTH-1:0] coef_q [NumCoef];
    logic        [7:0]            qt_q   [NumCoef];
    logic signed [8:0]            res_q  [NumCoef];

    // Operand selection for the current index
    logic signed [COEF_WIDTH-1:0] cur_coef;
    logic [7:0]    cur_qt;
    logic [7:0]    qeff;
    logic [NW-1:0] ext_c;
    logic [NW-1:0] abs_c;
    logic [NW-1:0] load_n;

    assign cur_coef = coef_q[idx_q];
    assign cur_qt   = qt_q[idx_q];
    assign qeff     = (cur_qt == 8'd0) ? 8'd1 : cur_qt;
    assign ext_c    = {cur_coef[COEF_WIDTH-1], cur_coef};
    assign abs_c    = cur_coef[COEF_WIDTH-1] ? ({NW{1'b0}} - ext_c) : ext_c;
    // Adding half the step before truncating division rounds half away from zero.
    assign load_n   = abs_c + NW'(qeff >> 1);

    // One restoring-division step. The remainder is always below the divisor (<= 255), so the
    // difference fits in 8 bits whenever the trial subtraction succeeds.
    logic [8:0] trial;
    logic       ge;
    logic [7:0] sub8;

    assign trial = {rem_q, dvd_q[NW-1]};
    assign ge    = (trial >= {1'b0, div_q});
    assign sub8  = trial[7:0] - div_q;

    // Sign restore and saturation of the finished quotient
    logic signed [8:0] res_val;

    always_comb begin
        res_val = '0;
        if (neg_q) begin
            if (dvd_q > NW'(256)) begin
                res_val = 9'h100;
            end else begin
                res_val = 9'({NW{1'b0}} - dvd_q);
            end
        end else begin
            if (dvd_q > NW'(255)) begin
                res_val = 9'sd255;
            end else begin
                res_val = 9'(dvd_q);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        div_d    = div_q;
        neg_d    = neg_q;
        snap     = 1'b0;
        store_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_block_i) begin
                    snap    = 1'b1;
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                dvd_d   = load_n;
                rem_d   = '0;
                div_d   = qeff;
                neg_d   = cur_coef[COEF_WIDTH-1];
                cnt_d   = '0;
                state_d = StDivide;
            end
            StDivide: begin
                dvd_d = {dvd_q[NW-2:0], ge};
                rem_d = ge ? sub8 : trial[7:0];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(NW - 1)) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                store_en = 1'b1;
                if (idx_q == IdxW'(NumCoef - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
        end
    end

    // Input snapshot, taken on the start-sampling edge only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumCoef; i++) begin
                coef_q[i] <= '0;
                qt_q[i]   <= '0;
            end
        end else if (snap) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                for (int c = 0; c < BLOCK_SIZE; c++) begin
                    coef_q[r*BLOCK_SIZE+c] <= dct_coeffs_i[r][c];
                    qt_q[r*BLOCK_SIZE+c]   <= quant_table_i[r][c];
                end
            end
        end
    end

    // Result storage; elements not yet rewritten keep the previous block's values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumCoef; i++) begin
                res_q[i] <= '0;
            end
        end else if (store_en) begin
            res_q[idx_q] <= res_val;
        end
    end

    always_comb begin
        for (int r = 0; r < BLOCK_SIZE; r++) begin
            for (int c = 0; c < BLOCK_SIZE; c++) begin
                quantized_coeffs_o[r][c] = res_q[r*BLOCK_SIZE+c];
            end
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign block_done_o = (state_q == StDone);

endmodule

// File: tb/tb_quantize_block.sv
// Testbench for quantize_block: randomized and directed blocks, scoreboard of expected blocks,
// monitor comparing on every block_done pulse.
module tb_quantize_block;

    localparam int BS  = 8;
    localparam int W   = 16;
    localparam int N   = BS * BS;
    localparam int LAT = 1 + N * (W + 3);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic signed [W-1:0] dct [BS][BS];
    logic        [7:0]   qt  [BS][BS];
    logic signed [8:0]   qc  [BS][BS];
    logic busy;
    logic done;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int exp_q[$];
    int t_q[$];
    int last_exp[N];
    int pend[N];

    quantize_block #(
        .BLOCK_SIZE     (BS),
        .LOG2_BLOCK_SIZE(3),
        .COEF_WIDTH     (W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_block_i     (start),
        .dct_coeffs_i      (dct),
        .quant_table_i     (qt),
        .quantized_coeffs_o(qc),
        .busy_o            (busy),
        .block_done_o      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: round(|c|/Q) half away from zero, sign restored, clamped to 9-bit signed.
    function automatic int ref_q(int c, int q);
        int qe, m, r;
        qe = (q == 0) ? 1 : q;
        m  = (c < 0) ? -c : c;
        r  = (m + qe / 2) / qe;
        if (c < 0) r = -r;
        if (r > 255) r = 255;
        if (r < -256) r = -256;
        return r;
    endfunction

    function automatic int rnd_coef();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int count_diff(int lo, int hi, bit use_pend);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            if (int'(qc[i/BS][i%BS]) != (use_pend ? pend[i] : last_exp[i])) n++;
        end
        return n;
    endfunction

    task automatic fill_random(bit zero_q_ok);
        for (int r = 0; r < BS; r++) begin
            for (int c = 0; c < BS; c++) begin
                dct[r][c] = W'(rnd_coef());
                qt[r][c]  = 8'($urandom_range(zero_q_ok ? 0 : 1, 255));
            end
        end
    endtask

    task automatic fill_const(int cv, int qv);
        for (int r = 0; r < BS; r++) begin
            for (int c = 0; c < BS; c++) begin
                dct[r][c] = W'(cv);
                qt[r][c]  = 8'(qv);
            end
        end
    endtask

    // Called at a negedge while the DUT is idle; the next posedge samples the start.
    task automatic issue();
        for (int r = 0; r < BS; r++) begin
            for (int c = 0; c < BS; c++) begin
                pend[r*BS+c] = ref_q(int'(dct[r][c]), int'(qt[r][c]));
                exp_q.push_back(pend[r*BS+c]);
            end
        end
        t_q.push_back(cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_block();
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < LAT + 50; k++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no block_done expected one within %0d cycles", LAT + 50);
        end
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        repeat (4) @(negedge clk);
        check("outputs_stable_after_done", count_diff(0, N - 1, 1'b0), 0);
    endtask

    // Monitor: compares every presented block against the scoreboard
    always @(negedge clk) begin : monitor
        int t;
        int e;
        if (!rst && done) begin
            if (t_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got block_done at cycle %0d expected none", cyc);
            end else begin
                t = t_q.pop_front();
                check("latency", cyc - t, LAT);
                check("busy_in_done", int'(busy), 1);
                for (int i = 0; i < N; i++) begin
                    e = exp_q.pop_front();
                    check($sformatf("coef[%0d][%0d]", i / BS, i % BS), int'(qc[i/BS][i%BS]), e);
                    last_exp[i] = e;
                end
            end
            done_cnt++;
        end
    end

    initial begin : stim
        int d0;
        for (int i = 0; i < N; i++) last_exp[i] = 0;
        fill_const(0, 0);
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_coefs_nonzero", count_diff(0, N - 1, 1'b0), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: unit step, constant coefficient
        fill_const(5, 1);
        issue();
        finish_block();

        // 2: rounding half away from zero with Q=16
        fill_random(1'b1);
        for (int c = 0; c < BS; c++) qt[0][c] = 8'd16;
        dct[0][0] = 16'sd100;  dct[0][1] = -16'sd100;
        dct[0][2] = 16'sd24;   dct[0][3] = -16'sd24;
        dct[0][4] = 16'sd7;    dct[0][5] = 16'sd8;
        dct[0][6] = -16'sd8;   dct[0][7] = -16'sd7;
        issue();
        finish_block();

        // 3: saturation including the most-negative input
        fill_random(1'b1);
        for (int c = 0; c < BS; c++) qt[1][c] = 8'd1;
        dct[1][0] = 16'sd10000;  dct[1][1] = -16'sd10000;
        dct[1][2] = 16'h8000;    dct[1][3] = 16'sd32767;
        dct[1][4] = 16'sd255;    dct[1][5] = 16'sd256;
        dct[1][6] = -16'sd256;   dct[1][7] = -16'sd257;
        issue();
        finish_block();

        // 4: zero table acts as unit step; then mixed per-position tables
        fill_const(-3, 0);
        issue();
        finish_block();
        fill_random(1'b1);
        issue();
        finish_block();

        // 5: start while busy is ignored; inputs changed after the snapshot have no effect
        fill_random(1'b1);
        d0 = done_cnt;
        issue();
        fill_random(1'b1);
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fill_random(1'b0);
        repeat (589) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_block();
        repeat (20) @(negedge clk);
        check("single_done_pulse", done_cnt - d0, 1);

        // 6: reset mid-block aborts, restart gives correct result
        fill_random(1'b1);
        issue();
        repeat (299) @(negedge clk);
        check("partial_new_elems", count_diff(0, 14, 1'b1), 0);
        check("partial_old_elems", count_diff(15, N - 1, 1'b0), 0);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        for (int i = 0; i < N; i++) last_exp[i] = 0;
        check("abort_coefs_nonzero", count_diff(0, N - 1, 1'b0), 0);
        exp_q.delete();
        t_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_random(1'b1);
        issue();
        finish_block();

        // Further random blocks
        for (int b = 0; b < 3; b++) begin
            fill_random(1'b1);
            issue();
            finish_block();
        end

        check("scoreboard_empty", t_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
